// File: rtl/sensor_stream_pkg.sv
// Shared definitions for the multi-channel sensor stream emulator.
//   - Payload width and LFSR polynomial taps (x^16 + x^14 + x^13 + x^11 + 1)
//   - LFSR seed rule and single-step function
//   - Field-position helpers for the {ch_id, seq, payload} sample word
package sensor_stream_pkg;

  localparam int unsigned PAYLOAD_W = 16;

  // Tap mask for bits 15, 13, 12, 10 (polynomial exponents 16, 14, 13, 11).
  localparam logic [PAYLOAD_W-1:0] LFSR_TAPS = 16'hB400;

  // Channel c seeds with c+1 so no channel ever starts in the all-zero lock-up state.
  function automatic logic [PAYLOAD_W-1:0] lfsr_seed(int unsigned c);
    return PAYLOAD_W'(c + 1);
  endfunction

  // Fibonacci form, shifting left with the feedback bit entering at bit 0.
  function automatic logic [PAYLOAD_W-1:0] lfsr_step(logic [PAYLOAD_W-1:0] s);
    return {s[PAYLOAD_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  // Word layout, MSB first: ch_id (chw bits), seq (iw bits), zero-extended payload.
  function automatic int unsigned ch_lsb(int unsigned dw, int unsigned chw);
    return dw - chw;
  endfunction

  function automatic int unsigned seq_lsb(int unsigned dw, int unsigned chw, int unsigned iw);
    return dw - chw - iw;
  endfunction

endpackage

// File: rtl/sensor_chan_fifo.sv
// Per-channel sample FIFO with show-ahead read data.
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   push, wdata   write request and word; accepted when not full, or when full and popping
//   pop           read request; ignored when empty
//   rdata         word at the head of the queue (valid while !empty)
//   full, empty   occupancy flags, derived from the registered count
module sensor_chan_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW + 1)'(DEPTH));

  // A pop at full frees the slot the push lands in, so both proceed.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem_q[rptr_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/multi_sensor_stream_gen.sv
// Multi-channel sensor stream emulator feeding the Bluetooth packetiser path.
// Each channel emits a tagged sample every period[c] cycles into its own FIFO; a downstream
// arbiter picks a channel with rd_sel/rd_en and receives the word one cycle later.
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   enable        global run; 0 freezes every tick counter (reads continue)
//   mode          payload: 0 = sequence number, 1 = per-channel LFSR
//   period        packed per-channel periods, channel c at [c*PERIOD_WIDTH +: PERIOD_WIDTH]; 0 = off
//   rd_en, rd_sel single-cycle read request and channel select
//   ready         bit c set while FIFO c holds data
//   data_out      last delivered word {ch_id, seq, payload}; holds between reads
//   data_valid    1-cycle pulse with each delivered word
//   index         sequence number of the delivered word
//   rd_err        1-cycle pulse for a read of an empty or out-of-range channel
//   overflow      sticky per-channel flag: at least one sample was dropped
module multi_sensor_stream_gen
  import sensor_stream_pkg::*;
#(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned DATA_WIDTH   = 110,
  parameter int unsigned INDEX_WIDTH  = 6,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           mode,
  input  logic [NUM_CH*PERIOD_WIDTH-1:0] period,
  input  logic                           rd_en,
  input  logic [CH_W-1:0]                rd_sel,
  output logic [NUM_CH-1:0]              ready,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           data_valid,
  output logic [INDEX_WIDTH-1:0]         index,
  output logic                           rd_err,
  output logic [NUM_CH-1:0]              overflow
);

  localparam int unsigned PAD_W   = DATA_WIDTH - CH_W - INDEX_WIDTH;
  localparam int unsigned SEQ_LSB = seq_lsb(DATA_WIDTH, CH_W, INDEX_WIDTH);

  logic [NUM_CH-1:0]                 gen;
  logic [NUM_CH-1:0]                 pop;
  logic [NUM_CH-1:0]                 fifo_full;
  logic [NUM_CH-1:0]                 fifo_empty;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] fifo_rdata;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] wr_word;

  logic                   sel_empty;
  logic [DATA_WIDTH-1:0]  sel_word;
  logic                   rd_ok;

  logic [DATA_WIDTH-1:0]  data_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic                   data_valid_q;
  logic                   rd_err_q;
  logic [NUM_CH-1:0]      ovf_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PERIOD_WIDTH-1:0] per;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [INDEX_WIDTH-1:0]  seq_q;
    logic [PAYLOAD_W-1:0]    lfsr_q;
    logic [PAYLOAD_W-1:0]    payload;

    assign per = period[c*PERIOD_WIDTH +: PERIOD_WIDTH];

    // >= rather than == so a period shortened below the running count fires on the next edge.
    assign gen[c] = enable && (per != '0) && (cnt_q >= per - 1'b1);

    always_comb begin
      cnt_d = cnt_q;
      if (enable) begin
        if (per == '0 || gen[c]) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q  <= '0;
        seq_q  <= '0;
        lfsr_q <= lfsr_seed(c);
      end else begin
        cnt_q <= cnt_d;
        // seq advances even when the sample is dropped so gaps are visible downstream.
        if (gen[c]) begin
          seq_q  <= seq_q + 1'b1;
          lfsr_q <= lfsr_step(lfsr_q);
        end
      end
    end

    assign payload    = mode ? lfsr_q : PAYLOAD_W'(seq_q);
    assign wr_word[c] = {CH_W'(c), seq_q, PAD_W'(payload)};
    assign pop[c]     = rd_ok && (rd_sel == CH_W'(c));

    sensor_chan_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_WIDTH)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (gen[c]),
      .wdata (wr_word[c]),
      .pop   (pop[c]),
      .rdata (fifo_rdata[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
  end

  // An rd_sel beyond NUM_CH-1 matches no channel and so reads as empty, giving rd_err.
  always_comb begin
    sel_empty = 1'b1;
    sel_word  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rd_sel == CH_W'(c)) begin
        sel_empty = fifo_empty[c];
        sel_word  = fifo_rdata[c];
      end
    end
  end

  // Empty is judged on the registered state, so a same-cycle push never falls through.
  assign rd_ok = rd_en & ~sel_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q       <= '0;
      index_q      <= '0;
      data_valid_q <= 1'b0;
      rd_err_q     <= 1'b0;
      ovf_q        <= '0;
    end else begin
      data_valid_q <= rd_ok;
      rd_err_q     <= rd_en & ~rd_ok;
      if (rd_ok) begin
        data_q  <= sel_word;
        index_q <= sel_word[SEQ_LSB +: INDEX_WIDTH];
      end
      // A pop on the same channel makes room, so only an un-popped full FIFO drops.
      ovf_q <= ovf_q | (gen & fifo_full & ~pop);
    end
  end

  assign ready      = ~fifo_empty;
  assign data_out   = data_q;
  assign index      = index_q;
  assign data_valid = data_valid_q;
  assign rd_err     = rd_err_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_multi_sensor_stream_gen.sv
// Directed bench for multi_sensor_stream_gen, built with NUM_CH=6 so out-of-range selects exist.
module tb_multi_sensor_stream_gen;

  localparam int unsigned NCH = 6;
  localparam int unsigned DW  = 110;
  localparam int unsigned IW  = 6;
  localparam int unsigned PW  = 16;
  localparam int unsigned CW  = 3;

  // Hand-stepped LFSR sequence from seed 3 (channel 2).
  localparam logic [15:0] LFSR_EXP [16] = '{
    16'h0003, 16'h0006, 16'h000C, 16'h0018, 16'h0030, 16'h0060, 16'h00C0, 16'h0180,
    16'h0300, 16'h0600, 16'h0C01, 16'h1803, 16'h3007, 16'h600E, 16'hC01D, 16'h803B
  };

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              mode;
  logic [NCH*PW-1:0] period;
  logic              rd_en;
  logic [CW-1:0]     rd_sel;
  logic [NCH-1:0]    ready;
  logic [DW-1:0]     data_out;
  logic              data_valid;
  logic [IW-1:0]     index;
  logic              rd_err;
  logic [NCH-1:0]    overflow;

  int checks = 0;
  int errors = 0;

  multi_sensor_stream_gen #(
    .NUM_CH       (NCH),
    .DATA_WIDTH   (DW),
    .INDEX_WIDTH  (IW),
    .DEPTH        (4),
    .PERIOD_WIDTH (PW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .period     (period),
    .rd_en      (rd_en),
    .rd_sel     (rd_sel),
    .ready      (ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .index      (index),
    .rd_err     (rd_err),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_period(int ch, int val);
    period[ch*PW +: PW] = PW'(val);
  endtask

  function automatic logic [DW-1:0] word(int ch, int seq, logic [15:0] pl);
    logic [DW-1:0] w;
    w           = '0;
    w[DW-1 -: 3] = 3'(ch);
    w[DW-4 -: 6] = 6'(seq);
    w[15:0]     = pl;
    return w;
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    mode   = 1'b0;
    period = '0;
    rd_en  = 1'b0;
    rd_sel = '0;
    step();
    step();

    // Reset state
    check("rst_ready", 128'(ready), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_valid", 128'(data_valid), 128'(0));
    check("rst_err", 128'(rd_err), 128'(0));
    check("rst_data", 128'(data_out), 128'(0));
    check("rst_index", 128'(index), 128'(0));
    reset = 1'b0;

    // Test 1: channel 0 period 4 -> samples at cycles 4, 8, 12, 16
    set_period(0, 4);
    enable = 1'b1;
    step(); step(); step();
    check("t1_not_ready_c3", 128'(ready), 128'(0));
    step();
    check("t1_ready_c4", 128'(ready), 128'(6'b000001));
    for (int i = 0; i < 12; i++) step();
    check("t1_ready_c16", 128'(ready), 128'(6'b000001));
    check("t1_no_ovf", 128'(overflow), 128'(0));
    set_period(0, 0);

    // enable=0 freezes generation
    enable = 1'b0;
    set_period(4, 1);
    step(); step();
    check("frozen_ready", 128'(ready), 128'(6'b000001));
    set_period(4, 0);
    enable = 1'b1;

    rd_en  = 1'b1;
    rd_sel = 3'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_valid", 128'(data_valid), 128'(1));
      check("t1_index", 128'(index), 128'(i));
      check("t1_data", 128'(data_out), 128'(word(0, i, 16'(i))));
    end
    check("t1_drained", 128'(ready), 128'(0));
    step();
    check("t1_empty_err", 128'(rd_err), 128'(1));
    check("t1_empty_novalid", 128'(data_valid), 128'(0));
    check("t1_empty_hold", 128'(data_out), 128'(word(0, 3, 16'd3)));
    rd_en = 1'b0;
    step();
    check("t1_err_pulse", 128'(rd_err), 128'(0));

    // Test 2: channel 3 period 1, no reads -> fill then drop
    set_period(3, 1);
    step();
    check("t2_ready_1cyc", 128'(ready), 128'(6'b001000));
    step(); step(); step();
    check("t2_full_no_ovf", 128'(overflow), 128'(0));
    step();
    check("t2_ovf_set", 128'(overflow), 128'(6'b001000));
    set_period(3, 0);
    rd_en  = 1'b1;
    rd_sel = 3'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_index", 128'(index), 128'(i));
      check("t2_data", 128'(data_out), 128'(word(3, i, 16'(i))));
    end
    step();
    check("t2_empty_err", 128'(rd_err), 128'(1));
    rd_en = 1'b0;
    step();
    check("t2_ovf_sticky", 128'(overflow), 128'(6'b001000));

    // Test 3: LFSR payload on channel 2, read every cycle
    mode = 1'b1;
    set_period(2, 1);
    step();
    rd_en  = 1'b1;
    rd_sel = 3'd2;
    for (int k = 0; k < 16; k++) begin
      step();
      check("t3_valid", 128'(data_valid), 128'(1));
      check("t3_word", 128'(data_out), 128'(word(2, k, LFSR_EXP[k])));
    end
    rd_en = 1'b0;
    set_period(2, 0);
    mode = 1'b0;

    // Test 4: channel 5 full, gen and pop every cycle -> no drop
    set_period(5, 1);
    step(); step(); step(); step();
    check("t4_ready5", 128'(ready[5]), 128'(1));
    rd_en  = 1'b1;
    rd_sel = 3'd5;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t4_valid", 128'(data_valid), 128'(1));
      check("t4_index", 128'(index), 128'(i));
    end
    check("t4_data", 128'(data_out), 128'(word(5, 7, 16'd7)));
    check("t4_no_ovf5", 128'(overflow), 128'(6'b001000));
    rd_en = 1'b0;
    set_period(5, 0);

    // Test 5: out-of-range selects
    rd_en  = 1'b1;
    rd_sel = 3'd6;
    step();
    check("t5_err6", 128'(rd_err), 128'(1));
    check("t5_novalid6", 128'(data_valid), 128'(0));
    check("t5_hold6", 128'(data_out), 128'(word(5, 7, 16'd7)));
    rd_sel = 3'd7;
    step();
    check("t5_err7", 128'(rd_err), 128'(1));
    check("t5_hold7", 128'(index), 128'(7));
    rd_en = 1'b0;
    step();
    check("t5_err_clear", 128'(rd_err), 128'(0));

    // Test 6: asynchronous reset mid-burst
    set_period(1, 1);
    rd_en  = 1'b1;
    rd_sel = 3'd5;
    step();
    check("t6_pre_index", 128'(index), 128'(8));
    check("t6_pre_valid", 128'(data_valid), 128'(1));
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_ready", 128'(ready), 128'(0));
    check("t6_async_ovf", 128'(overflow), 128'(0));
    check("t6_async_valid", 128'(data_valid), 128'(0));
    check("t6_async_data", 128'(data_out), 128'(0));
    step();
    reset = 1'b0;
    rd_en = 1'b0;
    step();
    check("t6_ready_after", 128'(ready), 128'(6'b000010));
    rd_en  = 1'b1;
    rd_sel = 3'd1;
    step();
    check("t6_valid", 128'(data_valid), 128'(1));
    check("t6_index0", 128'(index), 128'(0));
    check("t6_data", 128'(data_out), 128'(word(1, 0, 16'd0)));
    rd_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
